// File: rtl/uart_ascii_rx.sv
// 8N1 UART receiver feeding the text-line shift register: framing check, printable-ASCII filter,
// one-cycle strobes for accepted characters, dropped bytes and framing errors.
module uart_ascii_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [6:0] ascii_out,
    output logic       ascii_valid,
    output logic       frame_err,
    output logic       drop,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [6:0]    r_ascii;
    logic [6:0]    w_ascii_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_ferr;
    logic          w_ferr_nxt;
    logic          r_drop;
    logic          w_drop_nxt;
    logic          r_busy;
    logic          w_rx_s;
    logic          w_printable;

    assign w_rx_s      = r_sync2;
    assign w_printable = (r_shift >= 8'h20) && (r_shift <= 8'h7E);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer + T_ONE;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_ascii_nxt  = r_ascii;
        w_valid_nxt  = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_drop_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // Mid-start sample rejects glitches shorter than half a bit
                if (r_timer == HALF_M1) begin
                    w_timer_nxt = '0;
                    if (!w_rx_s) begin
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_nxt  = '0;
                    w_shift_nxt  = {w_rx_s, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_timer == FULL_M1) begin
                    w_timer_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                        if (w_printable) begin
                            w_valid_nxt = 1'b1;
                            w_ascii_nxt = r_shift[6:0];
                        end else begin
                            w_drop_nxt = 1'b1;
                        end
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A stuck-low line reports once, then waits here for idle
                w_timer_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_ascii  <= 7'h20;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_drop   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_ascii  <= w_ascii_nxt;
            r_valid  <= w_valid_nxt;
            r_ferr   <= w_ferr_nxt;
            r_drop   <= w_drop_nxt;
            r_busy   <= (r_state != S_IDLE);
        end
    end

    assign ascii_out   = r_ascii;
    assign ascii_valid = r_valid;
    assign frame_err   = r_ferr;
    assign drop        = r_drop;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Scoreboard bench for uart_ascii_rx: stimulus pushes expected strobes, a monitor pops and compares.
module tb_uart_ascii_rx;

    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 3 + H + 9 * C;

    typedef struct {
        int         kind;   // 0 ascii_valid, 1 drop, 2 frame_err
        logic [6:0] ch;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [6:0] ascii_out;
    logic       ascii_valid;
    logic       frame_err;
    logic       drop;
    logic       busy;

    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] model_last = 7'h20;
    bit         mon_en = 1'b0;

    uart_ascii_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .ascii_out  (ascii_out),
        .ascii_valid(ascii_valid),
        .frame_err  (frame_err),
        .drop       (drop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            if (n_fail < 30) $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic check_lat(input string name, input int offset);
        n_checks++;
        if (offset < -1 || offset > 1) begin
            n_fail++;
            if (n_fail < 30) $display("FAIL %s at cycle %0d: off by %0d cycles, required within 1", name, cyc, offset);
        end
    endtask

    // Reference: what a correctly framed / misframed byte must produce, and when.
    function automatic exp_t ref_model(input logic [7:0] b, input bit stop_ok, input int t0);
        exp_t e;
        e.t  = t0 + LAT;
        e.ch = b[6:0];
        if (!stop_ok)                   e.kind = 2;
        else if (b >= 32 && b <= 126)   e.kind = 0;
        else                            e.kind = 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        q.push_back(ref_model(b, stop_ok, cyc));
        rx = 1'b0;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = stop_ok;
        hold(C);
    endtask

    initial begin : monitor
        exp_t e;
        int   nstr;
        int   kind_act;
        bit   busy_pend;
        busy_pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                nstr = int'(ascii_valid) + int'(drop) + int'(frame_err);
                if (busy_pend) begin
                    check("busy_fall", int'(busy), 0);
                    busy_pend = 1'b0;
                end
                if (nstr > 0) begin
                    check("one_strobe", nstr, 1);
                    if (q.size() == 0) begin
                        check("unexpected_strobe", nstr, 0);
                    end else begin
                        e        = q.pop_front();
                        kind_act = ascii_valid ? 0 : (drop ? 1 : 2);
                        check("strobe_kind", kind_act, e.kind);
                        check_lat("strobe_latency", cyc - e.t);
                        check("busy_at_strobe", int'(busy), 1);
                        if (e.kind == 0) begin
                            check("ascii_out", int'(ascii_out), int'(e.ch));
                            model_last = e.ch;
                        end
                        if (e.kind != 2) busy_pend = 1'b1;
                    end
                end
                if (!ascii_valid) check("ascii_hold", int'(ascii_out), int'(model_last));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        int t0;
        logic [7:0] b;
        bit err;
        rx    = 1'b1;
        reset = 1'b0;
        hold(3);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Idle line after reset
        hold(1000);
        check("rst_ascii_out", int'(ascii_out), 32);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(ascii_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_drop", int'(drop), 0);

        // Single character, then "HI!" back-to-back
        send(8'h41, 1'b1);
        hold(4);
        send(8'h48, 1'b1);
        send(8'h49, 1'b1);
        send(8'h21, 1'b1);
        hold(4);

        // Non-printable bytes
        send(8'h0D, 1'b1);
        hold(3);
        send(8'hC1, 1'b1);
        hold(3);

        // Misframed byte followed by a long break
        send(8'h41, 1'b0);
        hold(200);
        check("break_busy", int'(busy), 1);
        rx = 1'b1;
        hold(5);
        check("break_released", int'(busy), 0);
        send(8'h42, 1'b1);
        hold(4);

        // Short glitch on idle line
        t0 = cyc;
        rx = 1'b0;
        hold(3);
        rx = 1'b1;
        hold(2);
        check("glitch_busy", int'(busy), 1);
        hold(t0 + 3 + H - cyc);
        check("glitch_busy_pre", int'(busy), 1);
        tick();
        check("glitch_idle", int'(busy), 0);
        hold(C);

        // Reset in the middle of a 0x55 frame
        b  = 8'h55;
        rx = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = b[4];
        hold(5);
        check("busy_mid_frame", int'(busy), 1);
        reset      = 1'b0;
        model_last = 7'h20;
        rx         = 1'b1;
        tick();
        check("reset_busy", int'(busy), 0);
        reset = 1'b1;
        hold(2 * C);
        send(8'h55, 1'b1);
        hold(4);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            b   = 8'($urandom_range(0, 255));
            err = ($urandom_range(0, 9) == 0);
            send(b, !err);
            if (err) begin
                hold($urandom_range(0, 40));
                rx = 1'b1;
                hold($urandom_range(2, 10));
            end else begin
                hold($urandom_range(0, 12));
            end
        end

        hold(12 * C);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ascii_rx.md
# uart_ascii_rx

Serial character source for the VGA text line. Receives 8N1 UART frames on an asynchronous `rx` pin, checks framing, filters for printable 7-bit ASCII, and emits each accepted character as a one-cycle strobe. Sits directly upstream of the 8-slot text shift register: `ascii_out`/`ascii_valid` replace the switch value and debounced-button pulse as that register's load data and shift enable.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud); clock cycles per bit; legal range 8..4095
- `clk`  input  1  system clock (VGA/pixel-logic clock domain)
- `reset`  input  1  synchronous reset, active-low; sampled on `clk` rising edge
- `rx`  input  1  UART line, idle high, asynchronous to `clk`
- `ascii_out`  output  7  last accepted character; held stable between strobes
- `ascii_valid`  output  1  one-cycle strobe; `ascii_out` is new this cycle
- `frame_err`  output  1  one-cycle strobe; stop bit sampled low
- `drop`  output  1  one-cycle strobe; byte framed correctly but not printable (outside 0x20..0x7E)
- `busy`  output  1  high whenever the FSM is not in IDLE

## Operation
- Input sync: `rx` passes through 2 flip-flops (reset value 1) before any use; FSM sees `rx_s`.
- Bit timer: counter of width ceil(log2(CLKS_PER_BIT)); bit counter 3 bits; shift register 8 bits, LSB first.
- FSM states and transitions:
  - IDLE: on `rx_s`=0 clear timer, go START.
  - START: at timer = CLKS_PER_BIT/2 − 1 (integer divide) sample `rx_s`. If 0: clear timer and bit counter, go DATA. If 1: glitch, go IDLE with no strobe.
  - DATA: at timer = CLKS_PER_BIT − 1 shift `rx_s` into bit 7 of the shift register (right shift), clear timer; after the 8th sample go STOP.
  - STOP: at timer = CLKS_PER_BIT − 1 sample `rx_s`.
    - If 1 and byte in 0x20..0x7E: load `ascii_out` = byte[6:0], pulse `ascii_valid`, go IDLE.
    - If 1 and byte outside range: pulse `drop`, go IDLE.
    - If 0: pulse `frame_err`, go BREAK.
  - BREAK: wait for `rx_s`=1, then go IDLE. A line held low forever produces exactly one `frame_err`.
- Strobes are mutually exclusive; at most one strobe per frame.
- `ascii_out` changes only in the cycle `ascii_valid` is high.
- `busy` is high in START, DATA, STOP and BREAK.
- Reset mid-frame: the partial frame is discarded with no strobe, and the FSM returns to IDLE.

## Timing
- Reset values: `ascii_out`=0x20 (space, matching the display's blank slot), `ascii_valid`=0, `frame_err`=0, `drop`=0, `busy`=0; synchronizer FFs=1.
- All outputs are registered.
- Latency: falling edge of the start bit on `rx` to the `ascii_valid` cycle is 2 (sync) + 1 + (CLKS_PER_BIT/2) + 9·CLKS_PER_BIT clock cycles, ±1 for edge phase.
- Every sample point lies within ±1 clock of the mid-bit position.
- Back-to-back frames: the FSM is in IDLE and ready for the next start edge one cycle after the stop-bit sample, i.e. half a bit before the nominal stop-bit end. This tolerates a transmitter baud error of up to +2%.
- No ready/backpressure. Downstream must accept a strobe in any cycle; the shift register always can.

## Test plan
- Reset, then `rx` held high 1000 cycles -> all outputs at reset values, no strobes, `busy`=0.
- CLKS_PER_BIT=16, send 0x41 ('A') -> single `ascii_valid`, `ascii_out`=0x41, latency 2+1+8+144 = 155 cycles ±1 from start edge; `busy` falls the following cycle.
- Send "HI!" back-to-back with 1-bit stop only -> three `ascii_valid` strobes in order 0x48, 0x49, 0x21, with no `frame_err`.
- Send 0x0D, then 0xC1 -> two `drop` strobes, no `ascii_valid`; `ascii_out` retains its previous value.
- Send 0x41 with the stop bit forced 0, then hold `rx` low 200 cycles, then release and send 0x42 -> exactly one `frame_err`, FSM stays in BREAK until release, then `ascii_valid` with 0x42.
- 3-cycle low glitch on idle `rx` -> no strobe, back in IDLE before the mid-start sample + 1. Separately, assert `reset` low during DATA of a 0x55 frame -> no strobe, `busy`=0 the cycle after reset, and the next full frame is received correctly.
